rt_ibex_window_spill_ctrl: RTL

RT_IBEX_WINDOW_SPILL_CTRL -- requirements
Module: rt_ibex_window_spill_ctrl

---
 rtl/rt_ibex_pkg.sv | 22 ++
 rtl/rt_ibex_window_spill_ctrl_if.sv | 14 +
 rtl/rt_ibex_spill_frame_cnt.sv | 23 ++
 rtl/rt_ibex_window_spill_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/rt_ibex_pkg.sv
// rt_ibex_pkg: shared FSM states, spill frame geometry and spilled-register address table.
package rt_ibex_pkg;
  typedef enum logic [3:0] {
    IDLE, SAVE, INC, SPILL_REQ, SPILL_WAIT, DEC, RESTORE,
    FILL_REQ, FILL_WAIT, FILL_RESTORE, FILL_SAVE
  } state_e;
  localparam logic [3:0]  FrameWords = 4'd9;
  localparam logic [31:0] FrameBytes = 32'd36;
  // Words 0/1 carry mepc/mcause, so register slots start at frame word 2.
  function automatic logic [4:0] spill_reg(input logic [3:0] k);
    case (k)
      4'd2:    spill_reg = 5'd1;
      4'd3:    spill_reg = 5'd5;
      4'd4:    spill_reg = 5'd10;
      4'd5:    spill_reg = 5'd11;
      4'd6:    spill_reg = 5'd12;
      4'd7:    spill_reg = 5'd13;
      4'd8:    spill_reg = 5'd15;
      default: spill_reg = 5'd0;
    endcase
  endfunction
endpackage

// File: rtl/rt_ibex_window_spill_ctrl_if.sv
// rt_ibex_window_spill_ctrl_if: OBI-style data port between spill controller and memory.
interface rt_ibex_window_spill_ctrl_if;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  modport master (output data_req_o, data_we_o, data_addr_o, data_wdata_o,
                  input  data_gnt_i, data_rvalid_i, data_rdata_i);
  modport slave  (input  data_req_o, data_we_o, data_addr_o, data_wdata_o,
                  output data_gnt_i, data_rvalid_i, data_rdata_i);
endinterface

// File: rtl/rt_ibex_spill_frame_cnt.sv
// rt_ibex_spill_frame_cnt: frame word counter and word address for spill (below sp) and fill (at sp).
module rt_ibex_spill_frame_cnt
  import rt_ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_clr,
  input  logic        i_inc,
  input  logic        i_spill,
  input  logic [31:0] i_base,
  output logic [3:0]  o_k,
  output logic [31:0] o_addr,
  output logic        o_last
);
  logic [3:0] r_k;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_k <= 4'd0;
    else         r_k <= i_clr ? 4'd0 : i_inc ? r_k + 4'd1 : r_k;
  end
  assign o_k    = r_k;
  assign o_addr = (i_spill ? i_base - FrameBytes : i_base) + {26'd0, r_k, 2'b00};
  assign o_last = r_k == FrameWords - 4'd1;
endmodule

// File: rtl/rt_ibex_window_spill_ctrl.sv
// rt_ibex_window_spill_ctrl: register-window save/restore with frame spill/fill to memory on overflow.
module rt_ibex_window_spill_ctrl
  import rt_ibex_pkg::*;
#(
  parameter int unsigned NumRegisterWindows = 4,
  parameter logic [31:0] SpillBase          = 32'h0000_1000,
  parameter int unsigned MaxSpillDepth      = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        irq_entry_i,
  input  logic        mret_i,
  input  logic        window_full_i,
  input  logic [31:0] win_mcause_i,
  input  logic [31:0] win_mepc_i,
  output logic        increment_ptr_o,
  output logic        decrement_ptr_o,
  output logic        save_csr_o,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        rf_we_o,
  output logic        csr_restore_o,
  output logic [31:0] csr_mcause_o,
  output logic [31:0] csr_mepc_o,
  output logic        busy_o,
  output logic        err_o,
  rt_ibex_window_spill_ctrl_if.master data
);
  localparam int unsigned WinW = (NumRegisterWindows > 1) ? $clog2(NumRegisterWindows) : 1;
  localparam int unsigned SdW  = $clog2(MaxSpillDepth + 1);
  state_e          r_state, w_next;
  logic [WinW-1:0] r_win_depth;
  logic [SdW-1:0]  r_spill_depth;
  logic [31:0]     r_sp, r_mepc, r_mcause;
  logic            r_err, r_inc;
  logic            w_idle_err, w_err_set, w_beat, w_spill_done, w_fill_beat;
  logic            w_sd_zero, w_wd_zero, w_spill_full;
  logic [3:0]      w_k;
  logic [31:0]     w_addr;
  logic            w_last;
  assign w_sd_zero    = r_spill_depth == '0;
  assign w_wd_zero    = r_win_depth == '0;
  assign w_spill_full = r_spill_depth == SdW'(MaxSpillDepth);
  assign w_beat       = (r_state == SPILL_WAIT || r_state == FILL_WAIT) && data.data_rvalid_i;
  assign w_spill_done = r_state == SPILL_WAIT && data.data_rvalid_i && w_last;
  assign w_fill_beat  = r_state == FILL_WAIT && data.data_rvalid_i;
  rt_ibex_spill_frame_cnt u_frame_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clr   (r_state == IDLE),
    .i_inc   (w_beat && !w_last),
    .i_spill (r_state == SPILL_REQ),
    .i_base  (r_sp),
    .o_k     (w_k),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );
  always_comb begin
    w_next     = r_state;
    w_idle_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (irq_entry_i) begin
          w_idle_err = mret_i | w_spill_full;
          w_next     = w_spill_full ? IDLE : (w_sd_zero && !window_full_i) ? SAVE : SPILL_REQ;
        end else if (mret_i) begin
          w_idle_err = w_sd_zero && w_wd_zero;
          w_next     = !w_sd_zero ? FILL_REQ : !w_wd_zero ? DEC : IDLE;
        end
      end
      SAVE:         w_next = r_inc ? INC : IDLE;
      INC:          w_next = IDLE;
      SPILL_REQ:    w_next = data.data_gnt_i ? SPILL_WAIT : SPILL_REQ;
      SPILL_WAIT:   w_next = !data.data_rvalid_i ? SPILL_WAIT : w_last ? SAVE : SPILL_REQ;
      DEC:          w_next = RESTORE;
      RESTORE:      w_next = IDLE;
      FILL_REQ:     w_next = data.data_gnt_i ? FILL_WAIT : FILL_REQ;
      FILL_WAIT:    w_next = !data.data_rvalid_i ? FILL_WAIT : w_last ? FILL_RESTORE : FILL_REQ;
      FILL_RESTORE: w_next = FILL_SAVE;
      FILL_SAVE:    w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end
  assign w_err_set = busy_o ? (irq_entry_i | mret_i) : w_idle_err;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_win_depth   <= '0;
      r_spill_depth <= '0;
      r_sp          <= SpillBase;
      r_err         <= 1'b0;
      r_inc         <= 1'b0;
      r_mepc        <= '0;
      r_mcause      <= '0;
    end else begin
      r_state       <= w_next;
      r_err         <= r_err | w_err_set;
      r_inc         <= (r_state == IDLE) ? (w_next == SAVE) : r_inc;
      r_win_depth   <= (r_state == INC && r_win_depth != WinW'(NumRegisterWindows - 1)) ? r_win_depth + 1'b1 :
                       (r_state == DEC) ? r_win_depth - 1'b1 : r_win_depth;
      r_spill_depth <= w_spill_done ? r_spill_depth + 1'b1 :
                       (r_state == FILL_SAVE) ? r_spill_depth - 1'b1 : r_spill_depth;
      r_sp          <= w_spill_done ? r_sp - FrameBytes : (r_state == FILL_SAVE) ? r_sp + FrameBytes : r_sp;
      r_mepc        <= (w_fill_beat && w_k == 4'd0) ? data.data_rdata_i : r_mepc;
      r_mcause      <= (w_fill_beat && w_k == 4'd1) ? data.data_rdata_i : r_mcause;
    end
  end
  assign busy_o            = r_state != IDLE;
  assign err_o             = r_err;
  assign save_csr_o        = r_state == SAVE || r_state == FILL_SAVE;
  assign increment_ptr_o   = r_state == INC;
  assign decrement_ptr_o   = r_state == DEC;
  assign csr_restore_o     = r_state == RESTORE || r_state == FILL_RESTORE;
  assign csr_mepc_o        = (r_state == RESTORE) ? win_mepc_i : (r_state == FILL_RESTORE) ? r_mepc : '0;
  assign csr_mcause_o      = (r_state == RESTORE) ? win_mcause_i : (r_state == FILL_RESTORE) ? r_mcause : '0;
  assign rf_raddr_o        = (r_state == SPILL_REQ) ? spill_reg(w_k) : '0;
  assign rf_we_o           = w_fill_beat && w_k >= 4'd2;
  assign rf_waddr_o        = rf_we_o ? spill_reg(w_k) : '0;
  assign rf_wdata_o        = rf_we_o ? data.data_rdata_i : '0;
  assign data.data_req_o   = r_state == SPILL_REQ || r_state == FILL_REQ;
  assign data.data_we_o    = r_state == SPILL_REQ;
  assign data.data_addr_o  = data.data_req_o ? w_addr : '0;
  assign data.data_wdata_o = (r_state != SPILL_REQ) ? '0 : (w_k == 4'd0) ? win_mepc_i :
                             (w_k == 4'd1) ? win_mcause_i : rf_rdata_i;
endmodule
